// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one external combinational adder among NREQ requesters.
// Operands are registered toward the adder at grant; the sum is captured one cycle later.
module adder_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        result,
  output logic                    busy,
  output logic [WIDTH-1:0]        adder_a,
  output logic [WIDTH-1:0]        adder_b,
  input  logic [WIDTH-1:0]        adder_sum
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  logic [NREQ-1:0]   cand;
  logic              win_valid;
  logic [PW-1:0]     win_idx;
  logic [NREQ-1:0]   win_oh;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = op_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = op_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The requester just finishing still holds req in RESP, so mask it out.
  always_comb begin
    cand      = (state_q == RESP) ? (req & ~gnt_q) : req;
    win_valid = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!win_valid && cand[PW'(idx)]) begin
        win_valid   = 1'b1;
        win_idx     = PW'(idx);
        win_oh[PW'(idx)] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (win_valid) begin
          a_d     = a_arr[win_idx];
          b_d     = b_arr[win_idx];
          gnt_d   = win_oh;
          ptr_d   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
          state_d = ISSUE;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        result_d = adder_sum;
        done_d   = gnt_q;
        state_d  = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign result  = result_q;
  assign adder_a = a_q;
  assign adder_b = b_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: stimulus pushes expected {done, result} pairs; a negedge monitor pops and checks.
module tb_adder_arbiter;
  localparam int W = 16;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   result, adder_a, adder_b, adder_sum;
  logic           busy;

  typedef struct packed {
    logic [N-1:0] oh;
    logic [W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [N-1:0] prev_done = '0;

  always #5 clk = ~clk;

  // Shared adder living beside the arbiter.
  assign adder_sum = adder_a + adder_b;

  adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end else
      $display("ok   %s: 0x%0h", name, act);
  endtask

  // Monitor: every done cycle is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && done != '0) begin
      exp_t e;
      total++;
      if (prev_done != '0) begin
        bad++;
        $display("FAIL done_consecutive: got done=%b after done=%b, expected a gap", done, prev_done);
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=%b result=0x%0h, expected none", done, result);
      end else begin
        e = exp_q.pop_front();
        chk("sb_done", 32'(done), 32'(e.oh));
        chk("sb_result", 32'(result), 32'(e.res));
      end
    end
    prev_done = done;
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == '0 && cyc < 20);
    if (done == '0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected one", cyc);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] s, input string name);
    int cyc;
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    set_ops(i, a, b);
    exp_q.push_back({oh, s});
    req = oh;
    wait_done(cyc);
    chk({name, "_latency"}, 32'(cyc), 32'd2);
    chk({name, "_gnt"}, 32'(gnt), 32'(oh));
    req = '0;
    @(negedge clk);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_adder_a", 32'(adder_a), 32'd0);
    chk("rst_adder_b", 32'(adder_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request plus wrap-around sums; ptr ends back at 0.
    single(1, 16'h1234, 16'h0101, 16'h1335, "single1");
    single(0, 16'hFFFF, 16'h0001, 16'h0000, "wrap_ffff");
    single(2, 16'h8000, 16'h8000, 16'h0000, "wrap_8000");

    // Fairness: continuous requests, order 0,1,2,0,1,2 at 2-cycle spacing.
    set_ops(0, 16'h0001, 16'h0002);
    set_ops(1, 16'h0010, 16'h0020);
    set_ops(2, 16'h0100, 16'h0200);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({3'b001, 16'h0003});
      exp_q.push_back({3'b010, 16'h0030});
      exp_q.push_back({3'b100, 16'h0300});
    end
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_done(cyc);
      chk($sformatf("fair_spacing%0d", k), 32'(cyc), 32'd2);
    end
    req = '0;
    @(negedge clk);
    chk("fair_idle", 32'(busy), 32'd0);

    // Masking: req0 held through its done while req2 pending -> 0,2,0 then 0 via IDLE.
    set_ops(0, 16'h00AA, 16'h0055);
    set_ops(2, 16'h7000, 16'h1000);
    exp_q.push_back({3'b001, 16'h00FF});
    exp_q.push_back({3'b100, 16'h8000});
    exp_q.push_back({3'b001, 16'h00FF});
    exp_q.push_back({3'b001, 16'h00FF});
    req = 3'b101;
    wait_done(cyc);
    chk("mask_first", 32'(cyc), 32'd2);
    wait_done(cyc);
    chk("mask_to2", 32'(cyc), 32'd2);
    req = 3'b001;
    wait_done(cyc);
    chk("mask_back0", 32'(cyc), 32'd2);
    wait_done(cyc);
    chk("mask_via_idle", 32'(cyc), 32'd3);
    req = '0;
    @(negedge clk);

    // Operand change after grant must not affect the in-flight sum.
    set_ops(1, 16'h0010, 16'h0001);
    exp_q.push_back({3'b010, 16'h0011});
    req = 3'b010;
    @(negedge clk);
    op_a[1*W +: W] = 16'h0020;
    wait_done(cyc);
    chk("stable_latency", 32'(cyc), 32'd1);
    req = '0;
    @(negedge clk);

    // Reset during ISSUE: immediate clear, no stale done, restart from requester 0 priority.
    set_ops(0, 16'h0042, 16'h0001);
    req = 3'b001;
    @(negedge clk);
    chk("issue_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_result", 32'(result), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    set_ops(1, 16'h1111, 16'h2222);
    set_ops(2, 16'h0F0F, 16'h00F1);
    req = 3'b110;
    repeat (2) @(negedge clk);
    exp_q.push_back({3'b010, 16'h3333});
    exp_q.push_back({3'b100, 16'h1000});
    rst_n = 1'b1;
    wait_done(cyc);
    chk("post_rst_latency", 32'(cyc), 32'd2);
    chk("post_rst_gnt", 32'(gnt), 32'b010);
    req = 3'b100;
    wait_done(cyc);
    chk("post_rst_next", 32'(cyc), 32'd2);
    req = '0;
    repeat (4) @(negedge clk);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one combinational 16-bit adder instance among several datapath requesters, e.g. PC increment, branch-target and load/store effective-address generation. Each requester presents operands with a level request. The block selects one requester, drives the shared adder's inputs from registers, and captures the sum into a result register. It then returns a one-cycle done pulse to the selected requester. It sits between the requesters and the shared adder, which is instantiated beside it and wired through `adder_a`/`adder_b`/`adder_sum`.

## Interface
- `WIDTH`, 16: operand/result width in bits.
- `NREQ`, 3: number of requesters. Legal range is 2..8.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NREQ: level request, one bit per requester.
- `op_a` input NREQ*WIDTH: operand A of requester i, at bits [i*WIDTH +: WIDTH].
- `op_b` input NREQ*WIDTH: operand B of requester i, same packing.
- `gnt` output NREQ: one-hot, registered. Identifies the requester whose operation is in flight.
- `done` output NREQ: one-hot, registered, one-cycle pulse. Marks the result valid for that requester.
- `result` output WIDTH: registered sum. Valid only while `done` is nonzero, and held until the next capture.
- `busy` output 1: high in ISSUE and RESP.
- `adder_a` output WIDTH: registered operand A driven to the shared adder.
- `adder_b` output WIDTH: registered operand B driven to the shared adder.
- `adder_sum` input WIDTH: combinational sum returned by the shared adder.

## Operation
- States: IDLE, ISSUE, RESP.
- Reset (async, `rst_n`=0) forces these values:
  - state is IDLE.
  - `gnt`, `done`, `result`, `adder_a` and `adder_b` are 0.
  - `busy` is 0.
  - The round-robin pointer `ptr` is 0.
- Arbitration uses a candidate vector.
  - The winner is the first set bit of the candidate vector, searching from index `ptr` upward and wrapping from NREQ-1 to 0.
  - On a grant, `ptr` becomes (winner+1) mod NREQ.
- IDLE:
  - The candidate vector is `req`.
  - If it is nonzero: load the winner's operands into `adder_a`/`adder_b`, set `gnt` to the winner one-hot, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Capture `result` <= `adder_sum` and `done` <= `gnt`.
  - Go to RESP.
- RESP:
  - `done` is high for this cycle only and clears at the next edge unless a new RESP follows.
  - The candidate vector is `req & ~gnt`. This masks the finishing requester, whose `req` is still high.
  - If the candidates are nonzero, arbitrate as in IDLE and go to ISSUE (back-to-back operation).
  - Otherwise clear `gnt` and go to IDLE.
- Requester protocol:
  - Hold `req` and the operands stable from assertion until the edge that ends its `done` cycle.
  - A `req` still high after that edge is a new request with the operands present at that time.
- Operands are sampled only at the grant edge. Operand changes after the grant do not affect the in-flight operation.
- Arithmetic: `result` = (A+B) mod 2^WIDTH. Carry is discarded; there is no overflow flag.
- A `req` deassert during ISSUE does not abort the operation. The `done` pulse still occurs and the requester ignores it.

## Timing
- Latency: `req` sampled at edge E0 in IDLE leads to `done`/`result` valid in the cycle after E1, i.e. 2 cycles.
- Throughput: one operation per 2 cycles when requests are continuous (ISSUE/RESP alternation). It is one per 3 cycles when returning through IDLE.
- The shared adder's input-to-sum path must fit in one clock period.
- `done` is never asserted in two consecutive cycles.
- `gnt` stays constant from the grant edge through the end of the RESP cycle.
- Reset asserted mid-ISSUE or mid-RESP takes effect immediately: outputs go to their reset values and no `done` pulse is emitted. After release, arbitration restarts with requester 0 highest.

## Test plan
- Single request, NREQ=3: req=3'b010 with A=0x1234, B=0x0101 → gnt=3'b010 after E0, done=3'b010 and result=0x1335 in the cycle after E1, then IDLE.
- Wrap-around: A=0xFFFF, B=0x0001 → result=0x0000. A=0x8000, B=0x8000 → result=0x0000.
- Fairness: all three req held continuously, each re-requesting after its done → grant order 0,1,2,0,1,2. done pulses every 2 cycles with no gaps and no consecutive done cycles.
- Masking: req[0] held through its done while req[2] is pending → next grant goes to 2, not 0. If only req[0] is high, RESP goes to IDLE and re-grants 0 one cycle later.
- Operand stability: change op_a[1] from 0x0010 to 0x0020 the cycle after the grant with B=0x0001 → result=0x0011.
- Reset mid-ISSUE: drop rst_n asynchronously during ISSUE → gnt/done/result/busy go to 0 immediately, and no done follows release. With req=3'b110 after release, the grant goes to 1.
